// File: rtl/combo_tracker.sv
// Combo tracker: counts consecutive line-clearing locks, breaking on window or hold timeouts.
// Optional macro COMBO_TETRIS_BONUS_EN: a four-line clear adds 2 instead of 1.
module combo_tracker #(
    parameter int unsigned CLEAR_WINDOW = 64,
    parameter int unsigned HOLD_TICKS   = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_100HZ,
    input  logic       lock_pulse,
    input  logic       clear_pulse,
    input  logic [2:0] lines,
    input  logic       game_over,
    output logic [4:0] combo,
    output logic       combo_event
);

    localparam int unsigned WinW  = $clog2(CLEAR_WINDOW + 1);
    localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);
    localparam logic [WinW-1:0]  WinLoad  = WinW'(CLEAR_WINDOW);
    localparam logic [WinW-1:0]  WinOne   = WinW'(1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_TICKS);
    localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

    typedef enum logic [1:0] {StIdle, StWaitClear, StActive} state_e;

    state_e           state_q, state_d;
    logic [4:0]       combo_q, combo_d;
    logic             event_q, event_d;
    logic [WinW-1:0]  win_q, win_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             tick_q, tick_seen_q;

    logic       qualify;
    logic       tick_rise;
    logic [1:0] step;

    function automatic logic [4:0] sat_add(input logic [4:0] base, input logic [1:0] inc);
        logic [5:0] sum;
        sum = {1'b0, base} + {4'd0, inc};
        return (sum > 6'd31) ? 5'd31 : sum[4:0];
    endfunction

    assign qualify   = clear_pulse && (lines != 3'd0);
    // No edge may be reported until at least one sample has been taken after reset.
    assign tick_rise = tick_100HZ && !tick_q && tick_seen_q;

`ifdef COMBO_TETRIS_BONUS_EN
    assign step = lines[2] ? 2'd2 : 2'd1;
`else
    assign step = 2'd1;
`endif

    always_comb begin
        state_d = state_q;
        combo_d = combo_q;
        event_d = 1'b0;
        win_d   = win_q;
        hold_d  = hold_q;

        if (game_over) begin
            state_d = StIdle;
            combo_d = 5'd0;
            win_d   = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StActive: begin
                    if (lock_pulse && qualify) begin
                        combo_d = sat_add(combo_q, step);
                        event_d = 1'b1;
                        state_d = StActive;
                        hold_d  = HoldLoad;
                        win_d   = '0;
                    end else if (lock_pulse) begin
                        state_d = StWaitClear;
                        win_d   = WinLoad;
                    end else if (state_q == StActive && tick_rise) begin
                        if (hold_q <= HoldOne) begin
                            state_d = StIdle;
                            combo_d = 5'd0;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q - HoldOne;
                        end
                    end
                end
                StWaitClear: begin
                    // A new lock breaks the combo; a same-cycle clear then starts a fresh one.
                    if (lock_pulse && qualify) begin
                        combo_d = sat_add(5'd0, step);
                        event_d = 1'b1;
                        state_d = StActive;
                        hold_d  = HoldLoad;
                        win_d   = '0;
                    end else if (lock_pulse) begin
                        combo_d = 5'd0;
                        win_d   = WinLoad;
                    end else if (qualify) begin
                        combo_d = sat_add(combo_q, step);
                        event_d = 1'b1;
                        state_d = StActive;
                        hold_d  = HoldLoad;
                        win_d   = '0;
                    end else if (win_q <= WinOne) begin
                        state_d = StIdle;
                        combo_d = 5'd0;
                        win_d   = '0;
                    end else begin
                        win_d = win_q - WinOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    combo_d = 5'd0;
                    win_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            combo_q     <= 5'd0;
            event_q     <= 1'b0;
            win_q       <= '0;
            hold_q      <= '0;
            tick_q      <= 1'b0;
            tick_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            combo_q     <= combo_d;
            event_q     <= event_d;
            win_q       <= win_d;
            hold_q      <= hold_d;
            tick_q      <= tick_100HZ;
            tick_seen_q <= 1'b1;
        end
    end

    assign combo       = combo_q;
    assign combo_event = event_q;

endmodule

// File: tb/tb_combo_tracker.sv
// Self-checking bench for combo_tracker: directed scenarios plus randomized traffic
// compared cycle by cycle against a rule-level reference model.
module tb_combo_tracker;

    localparam int CW = 64;
    localparam int HT = 300;
`ifdef COMBO_TETRIS_BONUS_EN
    localparam bit Bonus = 1'b1;
`else
    localparam bit Bonus = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_100HZ;
    logic       lock_pulse;
    logic       clear_pulse;
    logic [2:0] lines;
    logic       game_over;
    logic [4:0] combo;
    logic       combo_event;

    combo_tracker #(
        .CLEAR_WINDOW(CW),
        .HOLD_TICKS  (HT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_100HZ (tick_100HZ),
        .lock_pulse (lock_pulse),
        .clear_pulse(clear_pulse),
        .lines      (lines),
        .game_over  (game_over),
        .combo      (combo),
        .combo_event(combo_event)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit tick_lvl    = 1'b0;

    // Reference model: combo value, whether a clear is awaited, cycles since the lock,
    // tick edges since the last award.
    int m_combo;
    bit m_waiting, m_live, m_ev, m_prev, m_seen;
    int m_age, m_ticks;

    function automatic void model_reset();
        m_combo = 0; m_waiting = 0; m_live = 0; m_ev = 0;
        m_prev = 0; m_seen = 0; m_age = 0; m_ticks = 0;
    endfunction

    function automatic void award(int add);
        m_combo   = (m_combo + add > 31) ? 31 : m_combo + add;
        m_ev      = 1;
        m_waiting = 0;
        m_live    = 1;
        m_ticks   = 0;
    endfunction

    function automatic void model_apply(bit lk, bit cl, int ln, bit go, bit tk);
        bit rise;
        bit qual;
        int add;
        rise   = tk && !m_prev && m_seen;
        qual   = cl && (ln != 0);
        add    = (Bonus && ln >= 4) ? 2 : 1;
        m_prev = tk;
        m_seen = 1;
        m_ev   = 0;
        if (go) begin
            m_combo = 0; m_waiting = 0; m_live = 0; m_age = 0; m_ticks = 0;
        end else if (lk) begin
            if (m_waiting) m_combo = 0;
            m_waiting = 1;
            m_live    = 0;
            m_age     = 0;
            if (qual) award(add);
        end else if (m_waiting) begin
            m_age++;
            if (qual) award(add);
            else if (m_age >= CW) begin
                m_combo   = 0;
                m_waiting = 0;
            end
        end else if (m_live && rise) begin
            m_ticks++;
            if (m_ticks >= HT) begin
                m_combo = 0;
                m_live  = 0;
            end
        end
    endfunction

    task automatic step(input string tag, input bit lk, input bit cl, input logic [2:0] ln,
                        input bit go);
        lock_pulse  = lk;
        clear_pulse = cl;
        lines       = ln;
        game_over   = go;
        tick_100HZ  = tick_lvl;
        @(posedge clk);
        model_apply(lk, cl, int'(ln), go, tick_lvl);
        #1;
        vectors++;
        if (combo !== 5'(m_combo) || combo_event !== m_ev) begin
            miscompares++;
            $display("FAIL %s: combo=%0d event=%0b, expected combo=%0d event=%0b",
                     tag, combo, combo_event, m_combo, m_ev);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic build_combo(input int n);
        for (int i = 0; i < n; i++) step("build", 1'b1, 1'b1, 3'd1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lock_pulse = 1'b0; clear_pulse = 1'b0; lines = 3'd0; game_over = 1'b0;
        tick_lvl = 1'b0; tick_100HZ = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (combo !== 5'd0 || combo_event !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: combo=%0d event=%0b, expected combo=0 event=0",
                     combo, combo_event);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        idle("reset_idle", 3);
        step("reset_stray_clear", 1'b0, 1'b1, 3'd2, 1'b0);
    endtask

    task automatic test_basic();
        do_reset();
        step("basic_lock", 1'b1, 1'b0, 3'd0, 1'b0);
        idle("basic_wait", 9);
        step("basic_clear", 1'b0, 1'b1, 3'd1, 1'b0);
        vectors++;
        if (combo !== 5'd1 || combo_event !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_first: combo=%0d event=%0b, expected combo=1 event=1",
                     combo, combo_event);
        end
        idle("basic_after", 1);
        vectors++;
        if (combo_event !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse_len: event=%0b, expected 0", combo_event);
        end
    endtask

    task automatic test_window();
        do_reset();
        build_combo(2);
        step("win_lock", 1'b1, 1'b0, 3'd0, 1'b0);
        idle("win_wait", CW - 1);
        step("win_last_clear", 1'b0, 1'b1, 3'd1, 1'b0);
        vectors++;
        if (combo !== 5'd3) begin
            miscompares++;
            $display("FAIL win_edge_clear: combo=%0d, expected 3", combo);
        end
        step("win_lock2", 1'b1, 1'b0, 3'd0, 1'b0);
        idle("win_wait2", CW - 1);
        vectors++;
        if (combo !== 5'd3) begin
            miscompares++;
            $display("FAIL win_before_expiry: combo=%0d, expected 3", combo);
        end
        idle("win_expire", 1);
        vectors++;
        if (combo !== 5'd0 || combo_event !== 1'b0) begin
            miscompares++;
            $display("FAIL win_expired: combo=%0d event=%0b, expected combo=0 event=0",
                     combo, combo_event);
        end
        step("win_late_clear", 1'b0, 1'b1, 3'd1, 1'b0);
    endtask

    task automatic test_saturate();
        int events;
        do_reset();
        events = 0;
        for (int i = 0; i < 33; i++) begin
            step("sat_pair", 1'b1, 1'b1, 3'd2, 1'b0);
            if (combo_event === 1'b1) events++;
        end
        vectors++;
        if (combo !== 5'd31 || events != 33) begin
            miscompares++;
            $display("FAIL saturate: combo=%0d events=%0d, expected combo=31 events=33",
                     combo, events);
        end
    endtask

    task automatic test_hold();
        do_reset();
        build_combo(3);
        for (int e = 1; e <= HT; e++) begin
            tick_lvl = 1'b0;
            idle("hold_low", 2);
            tick_lvl = 1'b1;
            idle("hold_high", 2);
            if (e == HT - 1) begin
                vectors++;
                if (combo !== 5'd3) begin
                    miscompares++;
                    $display("FAIL hold_299: combo=%0d, expected 3", combo);
                end
            end
        end
        vectors++;
        if (combo !== 5'd0) begin
            miscompares++;
            $display("FAIL hold_300: combo=%0d, expected 0", combo);
        end
        tick_lvl = 1'b0;
    endtask

    task automatic test_bonus();
        do_reset();
`ifdef COMBO_TETRIS_BONUS_EN
        build_combo(30);
        step("bonus_tetris", 1'b1, 1'b1, 3'd4, 1'b0);
        vectors++;
        if (combo !== 5'd31) begin
            miscompares++;
            $display("FAIL bonus_sat: combo=%0d, expected 31", combo);
        end
        do_reset();
        build_combo(5);
        step("bonus_lines6", 1'b1, 1'b1, 3'd6, 1'b0);
        vectors++;
        if (combo !== 5'd7) begin
            miscompares++;
            $display("FAIL bonus_lines6: combo=%0d, expected 7", combo);
        end
`else
        build_combo(5);
        step("plain_tetris", 1'b1, 1'b1, 3'd4, 1'b0);
        vectors++;
        if (combo !== 5'd6) begin
            miscompares++;
            $display("FAIL plain_tetris: combo=%0d, expected 6", combo);
        end
        step("plain_lines7", 1'b1, 1'b1, 3'd7, 1'b0);
        vectors++;
        if (combo !== 5'd7) begin
            miscompares++;
            $display("FAIL plain_lines7: combo=%0d, expected 7", combo);
        end
`endif
    endtask

    task automatic test_game_over();
        do_reset();
        build_combo(7);
        step("go_override", 1'b1, 1'b1, 3'd3, 1'b1);
        vectors++;
        if (combo !== 5'd0 || combo_event !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over: combo=%0d event=%0b, expected combo=0 event=0",
                     combo, combo_event);
        end
        step("go_stray_clear", 1'b0, 1'b1, 3'd2, 1'b0);
        build_combo(4);
        step("rst_lock", 1'b1, 1'b0, 3'd0, 1'b0);
        idle("rst_wait", 5);
        rst = 1'b1;
        #1;
        vectors++;
        if (combo !== 5'd0 || combo_event !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: combo=%0d event=%0b, expected combo=0 event=0",
                     combo, combo_event);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle("rst_after", 3);
        step("rst_stray_clear", 1'b0, 1'b1, 3'd2, 1'b0);
        idle("rst_after2", 2);
    endtask

    task automatic test_random();
        bit         lk, cl, go;
        logic [2:0] ln;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            lk = ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 3) == 0);
            // Simultaneous lock and clear while a clear is awaited is left to directed use.
            if (lk && cl && m_waiting) cl = 1'b0;
            ln = 3'($urandom_range(0, 7));
            go = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) == 0) tick_lvl = ~tick_lvl;
            step("random", lk, cl, ln, go);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_saturate();
        test_hold();
        test_bonus();
        test_game_over();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
